// File: rtl/booth_mul_sequencer.sv
// Command sequencer for booth_multiplier: accepts operands, issues ld / ld_pp,
// waits for the ld_p completion pulse and returns the product (or a timeout error).
module booth_mul_sequencer #(
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  output logic           mul_ld,
  output logic           mul_ld_pp,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_product,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_product,
  output logic           rsp_err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    LOAD_PP,
    WAIT_DONE,
    RESP
  } state_e;

  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           ld_q, ld_d;
  logic           ldpp_q, ldpp_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           done_seen_q, done_seen_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [2*W-1:0] rsp_product_q, rsp_product_d;
  logic           rsp_err_q, rsp_err_d;
  logic [7:0]     cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      ld_q          <= 1'b0;
      ldpp_q        <= 1'b0;
      cnt_q         <= '0;
      done_seen_q   <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      ld_q          <= ld_d;
      ldpp_q        <= ldpp_d;
      cnt_q         <= cnt_d;
      done_seen_q   <= done_seen_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // Strobes are computed one state ahead so each is a clean registered pulse.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    ld_d          = 1'b0;
    ldpp_d        = 1'b0;
    cnt_d         = cnt_q;
    done_seen_d   = done_seen_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          a_d         = req_a;
          b_d         = req_b;
          ld_d        = 1'b1;
          req_ready_d = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: state_d = GAP;
      GAP: begin
        ldpp_d  = 1'b1;
        state_d = LOAD_PP;
      end
      LOAD_PP: begin
        cnt_d       = '0;
        done_seen_d = 1'b0;
        state_d     = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_d = cnt_inc;
        if (mul_done) done_seen_d = 1'b1;
        // The falling edge of ld_p takes priority over a coincident timeout.
        if (done_seen_q && !mul_done) begin
          rsp_product_d = mul_product;
          rsp_err_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (cnt_inc == TimeoutCnt) begin
          rsp_product_d = '0;
          rsp_err_d     = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = req_ready_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign mul_ld      = ld_q;
  assign mul_ld_pp   = ldpp_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign rsp_err     = rsp_err_q;

endmodule
